// File: rtl/universal_shift_register_n_bit_if.sv
// rtl/universal_shift_register_n_bit_if.sv - control/data bundle for the N-bit universal shift register
interface universal_shift_register_n_bit_if #(
    parameter int WIDTH       = 8,
    parameter int COUNT_WIDTH = 4
);
    logic                   Enable_In;
    logic [2:0]             Op_Select_In;
    logic                   Serial_Left_Side_Data_In;
    logic                   Serial_Right_Side_Data_In;
    logic [WIDTH-1:0]       Parallel_Data_In;
    logic                   Start_In;
    logic [COUNT_WIDTH-1:0] Shift_Count_In;
    logic                   Serial_Left_Side_Data_Out;
    logic                   Serial_Right_Side_Data_Out;
    logic [WIDTH-1:0]       Parallel_Data_Out;
    logic                   Busy_Out;
    logic                   Done_Out;

    modport master (
        output Enable_In, Op_Select_In, Serial_Left_Side_Data_In, Serial_Right_Side_Data_In,
               Parallel_Data_In, Start_In, Shift_Count_In,
        input  Serial_Left_Side_Data_Out, Serial_Right_Side_Data_Out, Parallel_Data_Out,
               Busy_Out, Done_Out
    );

    modport slave (
        input  Enable_In, Op_Select_In, Serial_Left_Side_Data_In, Serial_Right_Side_Data_In,
               Parallel_Data_In, Start_In, Shift_Count_In,
        output Serial_Left_Side_Data_Out, Serial_Right_Side_Data_Out, Parallel_Data_Out,
               Busy_Out, Done_Out
    );
endinterface

// File: rtl/universal_shift_register_n_bit.sv
// rtl/universal_shift_register_n_bit.sv - parametrised universal shift register with counted burst mode
module universal_shift_register_n_bit #(
    parameter int WIDTH       = 8,
    parameter int COUNT_WIDTH = 4
) (
    input  logic                          Clk_In,
    input  logic                          Reset_In,
    universal_shift_register_n_bit_if.slave bus
);
    localparam logic [2:0] OP_HOLD = 3'd0;
    localparam logic [2:0] OP_SHL  = 3'd1;
    localparam logic [2:0] OP_SHR  = 3'd2;
    localparam logic [2:0] OP_LOAD = 3'd3;
    localparam logic [2:0] OP_ROL  = 3'd4;
    localparam logic [2:0] OP_ROR  = 3'd5;
    localparam logic [2:0] OP_ASR  = 3'd6;

    typedef enum logic {IDLE, BURST} state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       reg_q, reg_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [2:0]             op_q, op_d;
    logic                   done_q, done_d;
    logic                   start_ok;

    function automatic logic [WIDTH-1:0] apply_op(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] r,
        input logic             sl,
        input logic             sr,
        input logic [WIDTH-1:0] pd
    );
        case (op)
            OP_SHL:  apply_op = {r[WIDTH-2:0], sr};
            OP_SHR:  apply_op = {sl, r[WIDTH-1:1]};
            OP_LOAD: apply_op = pd;
            OP_ROL:  apply_op = {r[WIDTH-2:0], r[WIDTH-1]};
            OP_ROR:  apply_op = {r[0], r[WIDTH-1:1]};
            OP_ASR:  apply_op = {r[WIDTH-1], r[WIDTH-1:1]};
            default: apply_op = r;
        endcase
    endfunction

    // Only genuine shift/rotate ops may open a burst; hold and load run as single ops.
    assign start_ok = bus.Start_In && (bus.Op_Select_In inside {OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_ASR});

    always_comb begin
        state_d = state_q;
        reg_d   = reg_q;
        count_d = count_q;
        op_d    = op_q;
        done_d  = 1'b0;
        if (bus.Enable_In) begin
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        if (bus.Shift_Count_In == '0) begin
                            done_d = 1'b1;
                        end else begin
                            reg_d   = apply_op(bus.Op_Select_In, reg_q, bus.Serial_Left_Side_Data_In,
                                               bus.Serial_Right_Side_Data_In, bus.Parallel_Data_In);
                            op_d    = bus.Op_Select_In;
                            count_d = bus.Shift_Count_In - COUNT_WIDTH'(1);
                            if (bus.Shift_Count_In == COUNT_WIDTH'(1)) begin
                                done_d = 1'b1;
                            end else begin
                                state_d = BURST;
                            end
                        end
                    end else begin
                        reg_d = apply_op(bus.Op_Select_In, reg_q, bus.Serial_Left_Side_Data_In,
                                         bus.Serial_Right_Side_Data_In, bus.Parallel_Data_In);
                    end
                end
                BURST: begin
                    reg_d   = apply_op(op_q, reg_q, bus.Serial_Left_Side_Data_In,
                                       bus.Serial_Right_Side_Data_In, bus.Parallel_Data_In);
                    count_d = count_q - COUNT_WIDTH'(1);
                    if (count_q == COUNT_WIDTH'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(negedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            state_q <= IDLE;
            reg_q   <= '0;
            count_q <= '0;
            op_q    <= OP_HOLD;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            count_q <= count_d;
            op_q    <= op_d;
            done_q  <= done_d;
        end
    end

    assign bus.Parallel_Data_Out          = reg_q;
    assign bus.Serial_Left_Side_Data_Out  = reg_q[WIDTH-1];
    assign bus.Serial_Right_Side_Data_Out = reg_q[0];
    assign bus.Busy_Out                   = (state_q == BURST);
    // The completion pulse is suppressed while the block is disabled.
    assign bus.Done_Out                   = done_q & bus.Enable_In;
endmodule

// File: tb/tb_universal_shift_register_n_bit.sv
// tb/tb_universal_shift_register_n_bit.sv - self-checking bench for universal_shift_register_n_bit
module tb_universal_shift_register_n_bit;
    localparam int W  = 8;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    universal_shift_register_n_bit_if #(.WIDTH(W), .COUNT_WIDTH(CW)) bus ();

    universal_shift_register_n_bit #(.WIDTH(W), .COUNT_WIDTH(CW)) dut (
        .Clk_In   (clk),
        .Reset_In (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: integer register value plus number of burst steps still owed.
    int m_reg, m_rem, m_op;
    bit m_done;

    function automatic int apply(int op, int r, int sl, int sr, int pd);
        case (op)
            1: return (r * 2) % 256 + sr;
            2: return sl * 128 + r / 2;
            3: return pd;
            4: return (r * 2) % 256 + r / 128;
            5: return (r % 2) * 128 + r / 2;
            6: return (r / 128) * 128 + r / 2;
            default: return r;
        endcase
    endfunction

    always @(negedge clk or posedge rst) begin : model
        int r, rem, op;
        bit d;
        if (rst) begin
            m_reg  <= 0;
            m_rem  <= 0;
            m_op   <= 0;
            m_done <= 1'b0;
        end else begin
            r = m_reg; rem = m_rem; op = m_op; d = 1'b0;
            if (bus.Enable_In) begin
                if (rem > 0) begin
                    r = apply(op, r, bus.Serial_Left_Side_Data_In, bus.Serial_Right_Side_Data_In, bus.Parallel_Data_In);
                    rem = rem - 1;
                    d = (rem == 0);
                end else if (bus.Start_In && (bus.Op_Select_In inside {3'd1, 3'd2, 3'd4, 3'd5, 3'd6})) begin
                    if (bus.Shift_Count_In != 0) begin
                        op  = bus.Op_Select_In;
                        r   = apply(op, r, bus.Serial_Left_Side_Data_In, bus.Serial_Right_Side_Data_In, bus.Parallel_Data_In);
                        rem = bus.Shift_Count_In - 1;
                    end
                    d = (rem == 0);
                end else begin
                    r = apply(bus.Op_Select_In, r, bus.Serial_Left_Side_Data_In, bus.Serial_Right_Side_Data_In, bus.Parallel_Data_In);
                end
            end
            m_reg  <= r;
            m_rem  <= rem;
            m_op   <= op;
            m_done <= d;
        end
    end

    always @(posedge clk) begin
        chk("par_out", bus.Parallel_Data_Out, m_reg);
        chk("sl_out",  bus.Serial_Left_Side_Data_Out, m_reg / 128);
        chk("sr_out",  bus.Serial_Right_Side_Data_Out, m_reg % 2);
        chk("busy",    bus.Busy_Out, m_rem > 0);
        chk("done",    bus.Done_Out, m_done && bus.Enable_In);
    end

    task automatic drive(input int op, input int sl = 0, input int sr = 0, input int pd = 0,
                         input int start = 0, input int cnt = 0, input int en = 1);
        bus.Op_Select_In              = 3'(op);
        bus.Serial_Left_Side_Data_In  = 1'(sl);
        bus.Serial_Right_Side_Data_In = 1'(sr);
        bus.Parallel_Data_In          = 8'(pd);
        bus.Start_In                  = 1'(start);
        bus.Shift_Count_In            = 4'(cnt);
        bus.Enable_In                 = 1'(en);
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    initial begin
        drive(0);
        #2;
        chk("rst_par", bus.Parallel_Data_Out, 0);
        chk("rst_busy", bus.Busy_Out, 0);
        chk("rst_done", bus.Done_Out, 0);
        cyc();
        rst = 1'b0;

        // Reset asserted in the middle of a cycle with reg = 0xFF.
        drive(3, 0, 0, 8'hFF); cyc();
        chk("load_ff", bus.Parallel_Data_Out, 8'hFF);
        drive(1, 0, 1); #3;
        rst = 1'b1; #1;
        chk("midrst_par", bus.Parallel_Data_Out, 0);
        chk("midrst_sl", bus.Serial_Left_Side_Data_Out, 0);
        chk("midrst_busy", bus.Busy_Out, 0);
        cyc();
        rst = 1'b0;

        drive(3, 0, 0, 8'hA5); cyc();
        chk("load_a5", bus.Parallel_Data_Out, 8'hA5);
        chk("a5_msb", bus.Serial_Left_Side_Data_Out, 1);
        drive(1, 0, 1); cyc();
        chk("shl_4b", bus.Parallel_Data_Out, 8'h4B);
        chk("4b_msb", bus.Serial_Left_Side_Data_Out, 0);
        drive(2, 0, 0); cyc();
        chk("shr_25", bus.Parallel_Data_Out, 8'h25);

        drive(3, 0, 0, 8'h81); cyc();
        drive(5); cyc();
        chk("ror_c0", bus.Parallel_Data_Out, 8'hC0);
        drive(3, 0, 0, 8'h80); cyc();
        drive(6); cyc();
        chk("asr_c0", bus.Parallel_Data_Out, 8'hC0);
        cyc();
        chk("asr_e0", bus.Parallel_Data_Out, 8'hE0);

        // Rotate-left burst of 3; opcode/start changes while busy must be ignored.
        drive(3, 0, 0, 8'h01); cyc();
        drive(4, 0, 0, 0, 1, 3); cyc();
        chk("b3_s1", bus.Parallel_Data_Out, 8'h02);
        chk("b3_busy1", bus.Busy_Out, 1);
        drive(3, 1, 1, 8'h5A, 1, 7); cyc();
        chk("b3_s2", bus.Parallel_Data_Out, 8'h04);
        chk("b3_busy2", bus.Busy_Out, 1);
        drive(0); cyc();
        chk("b3_s3", bus.Parallel_Data_Out, 8'h08);
        chk("b3_busy3", bus.Busy_Out, 0);
        chk("b3_done", bus.Done_Out, 1);
        cyc();
        chk("b3_done_clr", bus.Done_Out, 0);

        drive(1, 0, 1, 0, 1, 0); cyc();
        chk("c0_reg", bus.Parallel_Data_Out, 8'h08);
        chk("c0_busy", bus.Busy_Out, 0);
        chk("c0_done", bus.Done_Out, 1);
        drive(0); cyc();
        chk("c0_done_clr", bus.Done_Out, 0);

        drive(3, 0, 0, 8'hFF); cyc();
        drive(1, 0, 0, 0, 1, 10); cyc();
        chk("c10_s1", bus.Parallel_Data_Out, 8'hFE);
        drive(0);
        repeat (9) cyc();
        chk("c10_flush", bus.Parallel_Data_Out, 8'h00);
        chk("c10_done", bus.Done_Out, 1);

        // Burst of 4 with a three-cycle enable pause after step 2.
        drive(3, 0, 0, 8'h11); cyc();
        drive(4, 0, 0, 0, 1, 4); cyc();
        drive(0); cyc();
        chk("pause_s2", bus.Parallel_Data_Out, 8'h44);
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (3) cyc();
        chk("pause_frozen", bus.Parallel_Data_Out, 8'h44);
        chk("pause_busy", bus.Busy_Out, 1);
        drive(0); cyc();
        chk("pause_s3", bus.Parallel_Data_Out, 8'h88);
        cyc();
        chk("pause_s4", bus.Parallel_Data_Out, 8'h11);
        chk("pause_done", bus.Done_Out, 1);

        drive(2, 1, 0, 0, 1, 5); cyc();
        drive(0); cyc();
        rst = 1'b1; #1;
        chk("rst_burst_busy", bus.Busy_Out, 0);
        cyc();
        rst = 1'b0;
        repeat (5) begin
            cyc();
            chk("rst_burst_nodone", bus.Done_Out, 0);
        end

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 255), ($urandom_range(0, 3) == 0), $urandom_range(0, 15),
                  ($urandom_range(0, 4) != 0));
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b1;
                #2 rst = 1'b0;
            end
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/universal_shift_register_n_bit.md
# universal_shift_register_n_bit

Parametrised universal shift register, successor to the 4-bit USR family. It adds configurable width, rotate and arithmetic-shift modes, and a counted burst mode. In burst mode a single Start_In request performs N consecutive shifts with Busy/Done handshaking. It sits between serial links and parallel datapaths as a serialiser/deserialiser and barrel-style shifter.

## Interface
- WIDTH, 8, register width in bits (≥2)
- COUNT_WIDTH, 4, width of burst shift count
- Clk_In  input  1  clock; all state updates on falling edge
- Reset_In  input  1  reset, asynchronous, active-high
- Enable_In  input  1  high: operations/Start accepted; low: register, counter, Busy frozen
- Op_Select_In  input  3  0 hold, 1 shift left, 2 shift right, 3 parallel load, 4 rotate left, 5 rotate right, 6 arithmetic shift right, 7 hold (reserved)
- Serial_Left_Side_Data_In  input  1  bit entering MSB on shift right
- Serial_Right_Side_Data_In  input  1  bit entering LSB on shift left
- Parallel_Data_In  input  WIDTH  load value
- Start_In  input  1  burst request; latches Op_Select_In and Shift_Count_In
- Shift_Count_In  input  COUNT_WIDTH  number of burst steps
- Serial_Left_Side_Data_Out  output  1  reg[WIDTH-1]
- Serial_Right_Side_Data_Out  output  1  reg[0]
- Parallel_Data_Out  output  WIDTH  reg
- Busy_Out  output  1  burst in progress
- Done_Out  output  1  one-cycle pulse at burst completion

## Operation
- Reset: reg=0, counter=0, latched op=0, Busy_Out=0, Done_Out=0; all outputs therefore 0. Outputs always driven, never Z.
- Shift and rotate ops, applied at each active edge when Enable_In=1 and not busy:
  - shift left: {reg[W-2:0], SRin}
  - shift right: {SLin, reg[W-1:1]}
  - rotate left: {reg[W-2:0], reg[W-1]}
  - rotate right: {reg[0], reg[W-1:1]}
  - arithmetic shift right: {reg[W-1], reg[W-1:1]}
  - 0 and 7: hold
  - 3: reg=Parallel_Data_In
- States: IDLE, BURST.
- IDLE → BURST:
  - Condition: Start_In=1, Enable_In=1, Op_Select_In ∈ {1,2,4,5,6}, Shift_Count_In≠0.
  - Latch op and count. Perform the first step on the same edge. Counter=count−1.
  - If count=1: stay IDLE, pulse Done.
- Start with count=0 and a valid op: no shift, Done_Out pulses next cycle, Busy_Out stays 0.
- Start with op ∈ {0,3,7}: Start ignored; the op executes as a normal single-cycle op.
- BURST behaviour:
  - Each enabled edge applies the latched op and decrements the counter.
  - Serial inputs are sampled live on every step.
  - On the step where the counter reaches 0: return to IDLE, Busy_Out=0, Done_Out=1 for one cycle.
  - Op_Select_In, Start_In, Parallel_Data_In and Shift_Count_In are ignored while in BURST.
- Counts greater than WIDTH are legal. Shifts then flush the register entirely; rotates wrap modulo WIDTH.
- Enable_In=0: no state change in any state. A burst resumes where it paused. Done_Out is forced 0 while Enable_In=0.
- Start_In and Done_Out on the same edge (back-to-back burst) are accepted. A new burst starts, Busy_Out stays/returns high, and Done_Out still pulses for the completed burst.
- Reset mid-burst: immediate return to IDLE with reset values; no Done pulse.

## Timing
- All registered outputs update on the falling edge of Clk_In. Reset acts asynchronously on assertion.
- Single ops: result visible on Parallel_Data_Out after the same edge that samples them (latency 1 edge).
- Burst of N≥1 steps:
  - Busy_Out high for N−1 cycles after the start edge.
  - Result final after N enabled edges.
  - Done_Out high during the cycle following the last step.
- Count=0 burst: Done_Out high for the cycle after the start edge.
- Serial outputs reflect reg combinationally; no extra latency.

## Test plan
- Reset asserted mid-operation with reg=0xFF → all outputs 0 immediately; Busy_Out=0, Done_Out=0.
- Load 0xA5, then shift left with SRin=1 → 0x4B, Serial_Left_Side_Data_Out changes 1→0. Shift right with SLin=0 → 0x25.
- Load 0x81: rotate right → 0xC0. Load 0x80: arithmetic shift right twice → 0xC0, then 0xE0.
- Load 0x01, Start rotate left, count 3 → Busy_Out high 2 cycles, reg 0x02, 0x04, 0x08. Done_Out pulses once; Start/Op changes during Busy are ignored.
- Start with count 0 → Done_Out one pulse, Busy_Out never high, reg unchanged. Start with count 10 and shift left (SRin=0) on 0xFF → 0x00 after 10 edges.
- Burst count 4 with Enable_In low for 3 cycles after step 2 → reg frozen, Busy_Out held; completes after 2 more enabled edges. Reset during burst → no Done pulse.
